// File: rtl/beat_sequencer_pkg.sv
// Shared definitions for the beat sequencer: tempo encodings, FSM states,
// and per-song lengths used by the note-lookup ROMs.
package beat_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] TEMPO_NORM = 2'b00;
  localparam logic [1:0] TEMPO_FAST = 2'b01;
  localparam logic [1:0] TEMPO_SLOW = 2'b10;

  localparam int LITTLE_STAR_LEN = 96;

endpackage

// File: rtl/beat_sequencer_tempo_prescaler.sv
// Tempo prescaler: free-running count that wraps at div-1 while enabled,
// flagging the final cycle of each beat period.
module tempo_prescaler #(
  parameter int PW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [PW:0] div,
  output logic        tick
);

  logic [PW-1:0] count_q;
  logic [PW-1:0] count_d;

  // div is one bit wider than the count so the slow divider fits unreduced
  assign tick = ({1'b0, count_q} == (div - (PW+1)'(1)));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Beat index generator for the song ROMs: play/pause/stop FSM, looping,
// and a tempo selection that only takes effect at beat boundaries.
module beat_sequencer
  import beat_sequencer_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BEAT_HZ  = 8,
  parameter int SONG_LEN = LITTLE_STAR_LEN,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [1:0]       tempo_sel,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             beat_tick,
  output logic             playing,
  output logic             done
);

  localparam int DIV = CLK_HZ / BEAT_HZ;
  localparam int PW  = $clog2(2 * DIV);
  localparam int DW  = PW + 1;

  localparam logic [DW-1:0]    DIV_NORM = DW'(DIV);
  localparam logic [DW-1:0]    DIV_FAST = DW'(DIV >> 1);
  localparam logic [DW-1:0]    DIV_SLOW = DW'(DIV << 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(SONG_LEN);

  if (DIV < 2) begin : g_bad_div
    $error("beat_sequencer: CLK_HZ/BEAT_HZ must be at least 2");
  end
  if (SONG_LEN < 1 || SONG_LEN > 127 || SONG_LEN >= (1 << CNT_W)) begin : g_bad_len
    $error("beat_sequencer: SONG_LEN must be 1..127 and fit in CNT_W bits");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beatCnt_q, beatCnt_d;
  logic [DW-1:0]    div_q, div_d;
  logic             beatTick_q, beatTick_d;
  logic             done_q, done_d;
  logic [DW-1:0]    tempoDiv;
  logic             prescTick;
  logic             prescClr;

  assign prescClr = start | stop;

  tempo_prescaler #(.PW(PW)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_PLAY),
    .clr  (prescClr),
    .div  (div_q),
    .tick (prescTick)
  );

  always_comb begin
    case (tempo_sel)
      TEMPO_FAST: tempoDiv = DIV_FAST;
      TEMPO_SLOW: tempoDiv = DIV_SLOW;
      default:    tempoDiv = DIV_NORM;
    endcase
  end

  // Command priority stop > start > pause; a song end outranks a same-cycle pause
  always_comb begin
    state_d    = state_q;
    beatCnt_d  = beatCnt_q;
    div_d      = div_q;
    beatTick_d = 1'b0;
    done_d     = 1'b0;
    if (stop) begin
      state_d   = ST_IDLE;
      beatCnt_d = '0;
    end else if (start) begin
      state_d    = ST_PLAY;
      beatCnt_d  = CNT_W'(1);
      beatTick_d = 1'b1;
      div_d      = tempoDiv;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end
          if (prescTick) begin
            div_d = tempoDiv;
            if (beatCnt_q < LAST) begin
              beatCnt_d  = beatCnt_q + CNT_W'(1);
              beatTick_d = 1'b1;
            end else if (loop_en) begin
              beatCnt_d  = CNT_W'(1);
              beatTick_d = 1'b1;
            end else begin
              beatCnt_d = '0;
              state_d   = ST_DONE;
              done_d    = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (pause) begin
            state_d = ST_PLAY;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beatCnt_q  <= '0;
      div_q      <= DIV_NORM;
      beatTick_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beatCnt_q  <= beatCnt_d;
      div_q      <= div_d;
      beatTick_q <= beatTick_d;
      done_q     <= done_d;
    end
  end

  assign beat_cnt  = beatCnt_q;
  assign beat_tick = beatTick_q;
  assign playing   = (state_q == ST_PLAY);
  assign done      = done_q;

endmodule
